// File: rtl/fetch_unit.sv
// Instruction/operand fetch responder: owns the 16-bit PC, runs the ROM read
// handshake, and serves PC byte reads/loads toward the controller's data bus.
module fetch_unit #(
    parameter logic [15:0] RESET_PC = 16'h0000,
    parameter int unsigned TIMEOUT  = 15
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        fetch_req,
    input  logic        fetch_kind,
    input  logic        rom_ready,
    input  logic [7:0]  rom_data,
    output logic [15:0] rom_addr,
    output logic        rom_cs,
    output logic        rom_rd,
    output logic [7:0]  instruction,
    output logic        instr_valid,
    output logic [7:0]  operand,
    output logic        operand_valid,
    input  logic        pch_load,
    input  logic        pcl_load,
    input  logic [7:0]  bus_in,
    input  logic        pch_bus,
    input  logic        pcl_bus,
    output logic [7:0]  bus_out,
    output logic        bus_out_en,
    output logic        busy,
    output logic        fetch_err
);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_ADDR = 3'd1;
    localparam logic [2:0] S_WAIT = 3'd2;
    localparam logic [2:0] S_DONE = 3'd3;
    localparam logic [2:0] S_ERR  = 3'd4;

    localparam logic [7:0] TIMEOUT_C = 8'(TIMEOUT);

    logic [2:0]  state_q, state_d;
    logic [15:0] pc_q, pc_d;
    logic [15:0] rom_addr_q, rom_addr_d;
    logic        kind_q, kind_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [7:0]  instruction_q, instruction_d;
    logic [7:0]  operand_q, operand_d;
    logic        rom_cs_q, rom_cs_d;
    logic        rom_rd_q, rom_rd_d;
    logic        instr_valid_q, instr_valid_d;
    logic        operand_valid_q, operand_valid_d;
    logic        fetch_err_q, fetch_err_d;

    // Next-state, PC and capture logic for the fetch handshake.
    always_comb begin
        state_d         = state_q;
        pc_d            = pc_q;
        rom_addr_d      = rom_addr_q;
        kind_d          = kind_q;
        cnt_d           = cnt_q;
        instruction_d   = instruction_q;
        operand_d       = operand_q;
        instr_valid_d   = 1'b0;
        operand_valid_d = 1'b0;
        fetch_err_d     = 1'b0;
        case (state_q)
            S_IDLE: begin
                // Loads land first so a same-cycle fetch addresses the new PC.
                if (pch_load) begin
                    pc_d[15:8] = bus_in;
                end else begin
                    pc_d[15:8] = pc_q[15:8];
                end
                if (pcl_load) begin
                    pc_d[7:0] = bus_in;
                end else begin
                    pc_d[7:0] = pc_q[7:0];
                end
                if (fetch_req) begin
                    kind_d     = fetch_kind;
                    rom_addr_d = pc_d;
                    cnt_d      = 8'd0;
                    state_d    = S_ADDR;
                end else begin
                    state_d    = S_IDLE;
                end
            end
            S_ADDR: begin
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (rom_ready) begin
                    if (kind_q) begin
                        operand_d       = rom_data;
                        operand_valid_d = 1'b1;
                    end else begin
                        instruction_d   = rom_data;
                        instr_valid_d   = 1'b1;
                    end
                    pc_d    = pc_q + 16'd1;
                    state_d = S_DONE;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                    if (cnt_d == TIMEOUT_C) begin
                        fetch_err_d = 1'b1;
                        state_d     = S_ERR;
                    end else begin
                        state_d     = S_WAIT;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            S_ERR: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        rom_cs_d = (state_d == S_ADDR) || (state_d == S_WAIT);
        rom_rd_d = (state_d == S_WAIT);
    end

    // State and output registers with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q         <= S_IDLE;
            pc_q            <= RESET_PC;
            rom_addr_q      <= 16'h0000;
            kind_q          <= 1'b0;
            cnt_q           <= 8'd0;
            instruction_q   <= 8'h00;
            operand_q       <= 8'h00;
            rom_cs_q        <= 1'b0;
            rom_rd_q        <= 1'b0;
            instr_valid_q   <= 1'b0;
            operand_valid_q <= 1'b0;
            fetch_err_q     <= 1'b0;
        end else begin
            state_q         <= state_d;
            pc_q            <= pc_d;
            rom_addr_q      <= rom_addr_d;
            kind_q          <= kind_d;
            cnt_q           <= cnt_d;
            instruction_q   <= instruction_d;
            operand_q       <= operand_d;
            rom_cs_q        <= rom_cs_d;
            rom_rd_q        <= rom_rd_d;
            instr_valid_q   <= instr_valid_d;
            operand_valid_q <= operand_valid_d;
            fetch_err_q     <= fetch_err_d;
        end
    end

    // PC byte mux toward the data bus; high byte wins when both strobes are up.
    always_comb begin
        if (pch_bus) begin
            bus_out = pc_q[15:8];
        end else if (pcl_bus) begin
            bus_out = pc_q[7:0];
        end else begin
            bus_out = 8'h00;
        end
    end

    assign bus_out_en    = pch_bus | pcl_bus;
    assign busy          = (state_q != S_IDLE);
    assign rom_addr      = rom_addr_q;
    assign rom_cs        = rom_cs_q;
    assign rom_rd        = rom_rd_q;
    assign instruction   = instruction_q;
    assign instr_valid   = instr_valid_q;
    assign operand       = operand_q;
    assign operand_valid = operand_valid_q;
    assign fetch_err     = fetch_err_q;

endmodule
